seq_alu: RTL and testbench
==========================

# seq_alu

Clocked, parametrised ALU with a start/done handshake and a latched NZCV flag register. It adds iterative multiply, divide and modulo to the single-cycle arithmetic, logic and shift operations. Single-cycle operations complete in one clock; iterative ones take N_bits clocks. It sits between the register file and the flag/status logic of the datapath, replacing the purely combinational ALU.

## Interface
- N_bits, 32, operand/result width; must be ≥ 4 and a power of two.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- opcode  in  4  operation code, latched with start.
- a  in  N_bits  operand A, latched with start.
- b  in  N_bits  operand B, latched with start.
- busy  out  1  an iterative operation is in progress.
- done  out  1  one-cycle pulse: result and flags updated this cycle.
- result  out  N_bits  registered result.
- N, Z, C, V  out  1 each  registered flags.

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB (a−b), 0010 MUL (low N_bits of a·b, unsigned).
  - 0011 DIV (unsigned quotient), 0100 MOD (unsigned remainder).
  - 0101 AND, 0110 OR, 0111 XOR.
  - 1000 SHL, 1001 SHR (logical), 1010 ASR. Shift amount is b[$clog2(N_bits)-1:0]; upper bits of b are ignored.
  - 1011–1111 illegal: result=0, Z=1, N=C=V=0.
- N = result[N_bits-1] and Z = (result==0) for every opcode.
- C flag:
  - ADD: carry out.
  - SUB: 1 when a ≥ b unsigned (no borrow).
  - Shifts: last bit shifted out; 0 if the shift amount is 0.
  - MUL: 1 if the upper half of the 2·N_bits product is nonzero.
  - Logic, DIV, MOD: 0.
- V flag:
  - ADD/SUB: signed overflow.
  - MUL: V=C.
  - DIV/MOD by zero: V=1; otherwise 0.
  - Logic and shifts: 0.
- Divide by zero: DIV returns all ones, MOD returns a. Completes in one cycle with no iteration.
- FSM:
  - IDLE → ITER on start with MUL/DIV/MOD and b≠0 (MUL also with b=0).
  - ITER → IDLE after N_bits iterations, loading result and flags.
  - All other accepted starts stay in IDLE and load the result at the next edge.
- MUL is shift-add, one bit per cycle. DIV/MOD is restoring division, one quotient bit per cycle.
- result and flags hold their value until the next done.

## Timing
- Reset: result=0, N=0, Z=0, C=0, V=0, busy=0, done=0, state IDLE, iteration counter 0.
- start sampled at edge t:
  - Single-cycle op (including divide by zero): done=1 during cycle t+1 with the new result.
  - Iterative op: busy=1 during cycles t+1..t+N_bits; done=1 and busy=0 in cycle t+N_bits+1.
- start while busy=1 is ignored. Operands are not re-latched and no extra done is produced.
- Back-to-back: start may be asserted in the done cycle (state is IDLE) and is accepted. Throughput is one single-cycle op per clock.
- The operand buses may change freely after the accepting edge.
- rst asserted mid-operation aborts immediately. Outputs go to reset values and no done is emitted for the aborted op.

## Configuration
- SEQ_ALU_DIV_EN defined:
  - DIV and MOD are implemented as specified.
- SEQ_ALU_DIV_EN undefined:
  - Opcodes 0011 and 0100 are treated as illegal (single-cycle, result=0, Z=1).
  - No divider hardware is built; MUL is unaffected.

## Structure
- Package seq_alu_pkg holds:
  - opcode enum alu_op_e;
  - FSM state enum alu_state_e (IDLE, ITER);
  - packed struct alu_flags_t {N,Z,C,V}.
- One sub-module, seq_alu_muldiv:
  - iterative shift-add multiplier and restoring divider;
  - contains the shared counter and 2·N_bits accumulator;
  - load/step/finish controlled by the top FSM.
- Single-cycle operations and flag generation stay in seq_alu.

## Test plan
- N_bits=8, ADD a=0x7F b=0x01 → done at t+1, result=0x80, N=1 Z=0 C=0 V=1. Then SUB a=0x05 b=0x05 → result=0x00, Z=1 C=1 V=0.
- N_bits=32, MUL a=0x0001_0000 b=0x0001_0000 → busy for 32 cycles, done at t+33, result=0, Z=1 C=1 V=1. MUL 7×6 → 42, C=0.
- N_bits=8, DIV a=100 b=7 → 14 at t+9; MOD a=100 b=7 → 2. DIV a=9 b=0 → done at t+1, result=0xFF, V=1. Without SEQ_ALU_DIV_EN: DIV → result=0, Z=1.
- N_bits=8, SHL a=0x81 b=0x09 (shift 1) → result=0x02, C=1. ASR a=0x80 b=3 → 0xF0, N=1. Opcode 1111 → result=0, Z=1.
- start pulsed during MUL busy with a different opcode → ignored, exactly one done, MUL result intact. New start in the done cycle → accepted.
- rst raised at cycle 5 of a 32-bit DIV → busy=0, done never pulses, all outputs 0. The next ADD completes normally.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared types for seq_alu.
// Holds the opcode encoding, the control FSM states and the NZCV flag record.
package seq_alu_pkg;
   typedef enum logic [3:0] {
      OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_DIV = 4'h3,
      OP_MOD = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
      OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA
   } alu_op_e;
   typedef enum logic [0:0] {IDLE = 1'b0, ITER = 1'b1} alu_state_e;
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } alu_flags_t;
endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative shift-add multiplier and restoring divider, one bit per step.
// Ports: clk, rst (async, active high); load latches a/b and the mode (mul=1 multiply,
// mul=0 divide); step advances one iteration; nxt is the accumulator after the current
// step ({hi,lo} product, or {remainder,quotient}); last flags the final step.
// The divide datapath exists only when SEQ_ALU_DIV_EN is defined.
module seq_alu_muldiv
   import seq_alu_pkg::*;
#(
   parameter int N_bits = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                step,
   input  logic                mul,
   input  logic [N_bits-1:0]   a,
   input  logic [N_bits-1:0]   b,
   output logic [2*N_bits-1:0] nxt,
   output logic                last
);
   localparam int W = N_bits;
   logic [2*W-1:0]       acc;
   logic [W-1:0]         opnd;
   logic [$clog2(W)-1:0] cnt;
   logic                 mode;
   logic [W:0]           add;
   // Multiply: low half starts as the multiplier and is consumed LSB first while the
   // partial product shifts in from the top.
   assign add  = {1'b0, acc[2*W-1:W]} + {1'b0, opnd & {W{acc[0]}}};
   assign last = &cnt;
`ifdef SEQ_ALU_DIV_EN
   logic [W+1:0] dif;
   // Divide: trial-subtract the divisor from {remainder, next dividend bit}; keep the
   // difference only when it does not borrow.
   assign dif = {1'b0, acc[2*W-1:W-1]} - {2'b0, opnd};
   assign nxt = mode ? {add, acc[W-1:1]} :
                dif[W+1] ? {acc[2*W-2:0], 1'b0} : {dif[W-1:0], acc[W-2:0], 1'b1};
`else
   logic unused_mode;
   assign unused_mode = mode;
   assign nxt = {add, acc[W-1:1]};
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc  <= '0;
         opnd <= '0;
         cnt  <= '0;
         mode <= 1'b0;
      end else if (load) begin
         acc  <= {{W{1'b0}}, mul ? b : a};
         opnd <= mul ? a : b;
         cnt  <= '0;
         mode <= mul;
      end else if (step) begin
         acc <= nxt;
         cnt <= cnt + 1'b1;
      end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with start/done handshake, iterative MUL/DIV/MOD and latched NZCV.
// Ports: clk, rst (async, active high); start/opcode/a/b request (sampled when not busy);
// busy while iterating; done one-cycle pulse when result/N/Z/C/V update.
// Define SEQ_ALU_DIV_EN to build DIV/MOD; otherwise those opcodes behave as illegal.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int N_bits = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        opcode,
   input  logic [N_bits-1:0] a,
   input  logic [N_bits-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [N_bits-1:0] result,
   output logic              N,
   output logic              Z,
   output logic              C,
   output logic              V
);
   localparam int S = $clog2(N_bits);
   localparam int M = N_bits - 1;
   alu_state_e          state;
   alu_flags_t          flags, fin_f;
   logic [3:0]          op_q;
   logic [N_bits:0]     sum, dif;
   logic [S-1:0]        sh;
   logic [N_bits-1:0]   sc_r, it_r, fin_r;
   logic                sc_c, sc_v, it_c, fin_c, fin_v;
   logic                it_op, load, last;
   logic [2*N_bits-1:0] nxt;
   assign sum = {1'b0, a} + {1'b0, b};
   assign dif = {1'b0, a} - {1'b0, b};
   assign sh  = b[S-1:0];
`ifdef SEQ_ALU_DIV_EN
   // Divide by zero is resolved in the single-cycle path, so it never iterates.
   assign it_op = opcode == OP_MUL || ((opcode == OP_DIV || opcode == OP_MOD) && |b);
`else
   assign it_op = opcode == OP_MUL;
`endif
   assign busy = state == ITER;
   assign load = !busy && start && it_op;
   always_comb begin
      sc_r = '0;
      sc_c = 1'b0;
      sc_v = 1'b0;
      case (opcode)
         OP_ADD: begin
            {sc_c, sc_r} = sum;
            sc_v = (a[M] == b[M]) && (sum[M] != a[M]);
         end
         OP_SUB: begin
            sc_r = dif[M:0];
            sc_c = ~dif[N_bits];
            sc_v = (a[M] != b[M]) && (dif[M] != a[M]);
         end
         OP_AND: sc_r = a & b;
         OP_OR:  sc_r = a | b;
         OP_XOR: sc_r = a ^ b;
         // The extra bit beside the operand catches the last bit shifted out.
         OP_SHL: {sc_c, sc_r} = {1'b0, a} << sh;
         OP_SHR: {sc_r, sc_c} = {a, 1'b0} >> sh;
         OP_ASR: {sc_r, sc_c} = $signed({a, 1'b0}) >>> sh;
`ifdef SEQ_ALU_DIV_EN
         OP_DIV: begin
            sc_r = '1;
            sc_v = 1'b1;
         end
         OP_MOD: begin
            sc_r = a;
            sc_v = 1'b1;
         end
`endif
         default: ;
      endcase
   end
   assign it_r  = op_q == OP_MOD ? nxt[2*N_bits-1:N_bits] : nxt[M:0];
   assign it_c  = op_q == OP_MUL && |nxt[2*N_bits-1:N_bits];
   assign fin_r = busy ? it_r : sc_r;
   assign fin_c = busy ? it_c : sc_c;
   assign fin_v = busy ? it_c : sc_v;
   assign fin_f = '{n: fin_r[M], z: fin_r == '0, c: fin_c, v: fin_v};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         done   <= 1'b0;
         result <= '0;
         flags  <= '0;
         op_q   <= '0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            if (last) begin
               state  <= IDLE;
               result <= fin_r;
               flags  <= fin_f;
               done   <= 1'b1;
            end
         end else if (start) begin
            op_q <= opcode;
            if (it_op) state <= ITER;
            else begin
               result <= fin_r;
               flags  <= fin_f;
               done   <= 1'b1;
            end
         end
      end
   assign N = flags.n;
   assign Z = flags.z;
   assign C = flags.c;
   assign V = flags.v;
   seq_alu_muldiv #(.N_bits(N_bits)) u_md (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .step (busy),
      .mul  (opcode == OP_MUL),
      .a    (a),
      .b    (b),
      .nxt  (nxt),
      .last (last)
   );
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven scoreboard bench for seq_alu at N_bits=8 and N_bits=32.
module tb_seq_alu;
   import seq_alu_pkg::*;
   typedef struct {
      bit          w;
      logic [3:0]  op;
      logic [31:0] a, b, r;
      logic [3:0]  f;
      int          lat;
      string       nm;
   } vec_t;
   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;
      int          due;
      string       nm;
   } exp_t;
   logic clk = 0, rst8 = 1, rst32 = 1;
   logic start8 = 0, start32 = 0;
   logic [3:0] op8 = 0, op32 = 0;
   logic [7:0] a8 = 0, b8 = 0, res8;
   logic [31:0] a32 = 0, b32 = 0, res32;
   logic busy8, done8, n8, z8, c8, v8;
   logic busy32, done32, n32, z32, c32, v32;
   int cyc = 0, nvec = 0, nerr = 0;
   exp_t q8[$], q32[$];
   exp_t e8, e32;
   vec_t tv[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   seq_alu #(.N_bits(8)) d8 (
      .clk(clk), .rst(rst8), .start(start8), .opcode(op8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(res8), .N(n8), .Z(z8), .C(c8), .V(v8));
   seq_alu #(.N_bits(32)) d32 (
      .clk(clk), .rst(rst32), .start(start32), .opcode(op32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .result(res32), .N(n32), .Z(z32), .C(c32), .V(v32));
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst8) begin
         if (done8) begin
            if (q8.size() == 0) chk("d8 unexpected done", {31'b0, done8}, 32'd0);
            else begin
               e8 = q8.pop_front();
               chk({e8.nm, " result"}, {24'b0, res8}, e8.r);
               chk({e8.nm, " flags"}, {28'b0, n8, z8, c8, v8}, {28'b0, e8.f});
               chk({e8.nm, " done cycle"}, cyc, e8.due);
            end
         end else if (q8.size() != 0 && q8[0].due < cyc) begin
            chk({q8[0].nm, " done missing"}, cyc, q8[0].due);
            void'(q8.pop_front());
         end
      end
      if (!rst32) begin
         if (done32) begin
            if (q32.size() == 0) chk("d32 unexpected done", {31'b0, done32}, 32'd0);
            else begin
               e32 = q32.pop_front();
               chk({e32.nm, " result"}, res32, e32.r);
               chk({e32.nm, " flags"}, {28'b0, n32, z32, c32, v32}, {28'b0, e32.f});
               chk({e32.nm, " done cycle"}, cyc, e32.due);
            end
         end else if (q32.size() != 0 && q32[0].due < cyc) begin
            chk({q32[0].nm, " done missing"}, cyc, q32[0].due);
            void'(q32.pop_front());
         end
      end
   end
   task automatic issue8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                         input int lat, input logic [7:0] r, input logic [3:0] f, input string nm);
      start8 = 1;
      op8 = op;
      a8 = x;
      b8 = y;
      q8.push_back('{r: {24'b0, r}, f: f, due: cyc + 1 + lat, nm: nm});
      @(negedge clk);
      start8 = 0;
      op8 = 4'($urandom);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
   endtask
   task automatic issue32(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int lat, input logic [31:0] r, input logic [3:0] f, input string nm);
      start32 = 1;
      op32 = op;
      a32 = x;
      b32 = y;
      q32.push_back('{r: r, f: f, due: cyc + 1 + lat, nm: nm});
      @(negedge clk);
      start32 = 0;
      op32 = 4'($urandom);
      a32 = $urandom;
      b32 = $urandom;
   endtask
   task automatic drain();
      for (int k = 0; k < 200 && (q8.size() != 0 || q32.size() != 0); k++) @(negedge clk);
   endtask
   initial begin
      // {w, op, a, b, result, NZCV, latency, name}
      tv.push_back('{0, OP_ADD, 32'h7F, 32'h01, 32'h80, 4'b1001, 0, "add ovf"});
      tv.push_back('{0, OP_SUB, 32'h05, 32'h05, 32'h00, 4'b0110, 0, "sub eq"});
      tv.push_back('{0, OP_ADD, 32'hFF, 32'h01, 32'h00, 4'b0110, 0, "add carry"});
      tv.push_back('{0, OP_SUB, 32'h03, 32'h05, 32'hFE, 4'b1000, 0, "sub borrow"});
      tv.push_back('{0, OP_SUB, 32'h80, 32'h01, 32'h7F, 4'b0011, 0, "sub ovf"});
      tv.push_back('{0, OP_AND, 32'hF0, 32'h3C, 32'h30, 4'b0000, 0, "and"});
      tv.push_back('{0, OP_OR,  32'hF0, 32'h0C, 32'hFC, 4'b1000, 0, "or"});
      tv.push_back('{0, OP_XOR, 32'hAA, 32'hAA, 32'h00, 4'b0100, 0, "xor"});
      tv.push_back('{0, OP_SHL, 32'h81, 32'h09, 32'h02, 4'b0010, 0, "shl 1"});
      tv.push_back('{0, OP_SHR, 32'h81, 32'h01, 32'h40, 4'b0010, 0, "shr 1"});
      tv.push_back('{0, OP_ASR, 32'h80, 32'h03, 32'hF0, 4'b1000, 0, "asr 3"});
      tv.push_back('{0, OP_SHL, 32'h55, 32'h00, 32'h55, 4'b0000, 0, "shl 0"});
      tv.push_back('{0, OP_SHR, 32'h01, 32'h10, 32'h01, 4'b0000, 0, "shr upper b"});
      tv.push_back('{0, OP_ASR, 32'h40, 32'h07, 32'h00, 4'b0110, 0, "asr 7"});
      tv.push_back('{0, 4'hF,   32'hFF, 32'hFF, 32'h00, 4'b0100, 0, "illegal F"});
      tv.push_back('{0, 4'hB,   32'h12, 32'h34, 32'h00, 4'b0100, 0, "illegal B"});
      tv.push_back('{0, OP_MUL, 32'h07, 32'h06, 32'h2A, 4'b0000, 8, "mul8 7x6"});
      tv.push_back('{0, OP_MUL, 32'h10, 32'h10, 32'h00, 4'b0111, 8, "mul8 hi"});
      tv.push_back('{0, OP_MUL, 32'hFF, 32'hFF, 32'h01, 4'b0011, 8, "mul8 ff"});
      tv.push_back('{0, OP_MUL, 32'h05, 32'h00, 32'h00, 4'b0100, 8, "mul8 x0"});
`ifdef SEQ_ALU_DIV_EN
      tv.push_back('{0, OP_DIV, 32'd100, 32'd7, 32'd14, 4'b0000, 8, "div 100/7"});
      tv.push_back('{0, OP_MOD, 32'd100, 32'd7, 32'd2,  4'b0000, 8, "mod 100%7"});
      tv.push_back('{0, OP_DIV, 32'd9, 32'd0, 32'hFF, 4'b1001, 0, "div by 0"});
      tv.push_back('{0, OP_MOD, 32'd9, 32'd0, 32'h09, 4'b0001, 0, "mod by 0"});
      tv.push_back('{0, OP_DIV, 32'hFF, 32'd1, 32'hFF, 4'b1000, 8, "div ff/1"});
      tv.push_back('{1, OP_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 4'b0000, 32, "div32"});
      tv.push_back('{1, OP_MOD, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 4'b0000, 32, "mod32"});
`else
      tv.push_back('{0, OP_DIV, 32'd100, 32'd7, 32'd0, 4'b0100, 0, "div off"});
      tv.push_back('{0, OP_MOD, 32'd100, 32'd7, 32'd0, 4'b0100, 0, "mod off"});
      tv.push_back('{0, OP_DIV, 32'd9, 32'd0, 32'd0, 4'b0100, 0, "div0 off"});
`endif
      tv.push_back('{1, OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 4'b0111, 32, "mul32 hi"});
      tv.push_back('{1, OP_MUL, 32'd7, 32'd6, 32'd42, 4'b0000, 32, "mul32 7x6"});
      tv.push_back('{1, OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 4'b1001, 0, "add32 ovf"});
      tv.push_back('{1, OP_SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 4'b1000, 0, "sub32 borrow"});
      tv.push_back('{1, OP_SHL, 32'h1, 32'h3F, 32'h8000_0000, 4'b1000, 0, "shl32 31"});
      repeat (2) @(negedge clk);
      chk("d8 in reset", {18'b0, busy8, done8, n8, z8, c8, v8, res8}, 32'd0);
      chk("d32 in reset", {26'b0, busy32, done32, n32, z32, c32, v32}, 32'd0);
      rst8 = 0;
      rst32 = 0;
      @(negedge clk);
      chk("d8 after reset", {18'b0, busy8, done8, n8, z8, c8, v8, res8}, 32'd0);
      chk("d32 result after reset", res32, 32'd0);
      foreach (tv[i]) begin
         if (tv[i].w) issue32(tv[i].op, tv[i].a, tv[i].b, tv[i].lat, tv[i].r, tv[i].f, tv[i].nm);
         else issue8(tv[i].op, tv[i].a[7:0], tv[i].b[7:0], tv[i].lat, tv[i].r[7:0], tv[i].f, tv[i].nm);
         drain();
      end
      issue8(OP_ADD, 8'h01, 8'h02, 0, 8'h03, 4'b0000, "b2b add");
      issue8(OP_SUB, 8'h03, 8'h01, 0, 8'h02, 4'b0010, "b2b sub");
      issue8(OP_OR,  8'h00, 8'h00, 0, 8'h00, 4'b0100, "b2b or");
      drain();
      start8 = 1;
      op8 = OP_MUL;
      a8 = 8'd7;
      b8 = 8'd6;
      q8.push_back('{r: 32'd42, f: 4'b0000, due: cyc + 9, nm: "mul busy-start"});
      @(negedge clk);
      start8 = 0;
      chk("mul busy first cycle", {31'b0, busy8}, 32'd1);
      repeat (2) @(negedge clk);
      start8 = 1;
      op8 = OP_ADD;
      a8 = 8'h01;
      b8 = 8'h01;
      @(negedge clk);
      start8 = 0;
      chk("mul busy after ignored start", {31'b0, busy8}, 32'd1);
      for (int k = 0; k < 20 && !done8; k++) @(negedge clk);
      chk("mul done seen", {31'b0, done8}, 32'd1);
      chk("busy low in done cycle", {31'b0, busy8}, 32'd0);
      issue8(OP_ADD, 8'h10, 8'h20, 0, 8'h30, 4'b0000, "start in done cycle");
      drain();
`ifdef SEQ_ALU_DIV_EN
      op32 = OP_DIV;
`else
      op32 = OP_MUL;
`endif
      start32 = 1;
      a32 = 32'd1000;
      b32 = 32'd3;
      @(negedge clk);
      start32 = 0;
      repeat (4) @(negedge clk);
      chk("abort busy before rst", {31'b0, busy32}, 32'd1);
      rst32 = 1;
      #1;
      chk("abort ctrl/flags", {26'b0, busy32, done32, n32, z32, c32, v32}, 32'd0);
      chk("abort result", res32, 32'd0);
      @(negedge clk);
      rst32 = 0;
      repeat (40) @(negedge clk);
      chk("abort stays idle", {30'b0, busy32, done32}, 32'd0);
      issue32(OP_ADD, 32'd2, 32'd3, 0, 32'd5, 4'b0000, "add after abort");
      drain();
      repeat (2) @(negedge clk);
      chk("scoreboard empty", q8.size() + q32.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
